// File: rtl/usb_rst_sequencer.sv
// usb_rst_sequencer
// Drives the active-low reset of an external USB controller. It holds the
// reset low for a minimum pulse, lets the chip settle, then waits for the
// chip-ready indication. The outcome (READY or FAULT) and a sequence counter
// are exposed on a small Avalon-MM slave.
//
// Optional feature: define USB_RST_IRQ_EN to build the pending/interrupt
// logic. Without it, addr2 reads 0, addr2 writes are ignored and irq is 0.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   req_in              reset request level (clk domain); a rising edge starts a sequence
//   ready_in            asynchronous chip-ready from the controller
//   address, chipselect, read, write, writedata, readdata
//                       Avalon-MM slave, read latency 1
//   usb_rst_n           active-low reset to the controller
//   busy, ready, fault  registered sequencer status
//   irq                 interrupt request (|pending, registered)
module usb_rst_sequencer #(
  parameter int RST_CYCLES     = 500,
  parameter int SETTLE_CYCLES  = 5000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_in,
  input  logic        ready_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        busy,
  output logic        ready,
  output logic        fault,
  output logic        irq
);

  localparam int MAX_AB  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_READY    = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          rdy_meta, rdy_sync;
  logic          req_q, req_rise;
  logic          enter_done, enter_fault;
  logic [15:0]   seq_count;
  logic [1:0]    pending_rd;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  // ready_in is asynchronous; only rdy_sync may be used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      rdy_meta <= ready_in;
      rdy_sync <= rdy_meta;
      req_q    <= req_in;
    end
  end

  assign req_rise = req_in & ~req_q;

  // The ASSERT counter saturates at its last value so that a long-held
  // req_in cannot wrap the counter; the pulse simply extends until req_in drops.
  always_comb begin
    state_next = state;
    count_next = count;
    if (req_rise) begin
      state_next = ST_ASSERT;
      count_next = '0;
    end else begin
      unique case (state)
        ST_ASSERT: begin
          if (count == RST_LAST) begin
            if (!req_in) begin
              state_next = ST_SETTLE;
              count_next = '0;
            end
          end else begin
            count_next = count + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (count == SETTLE_LAST) begin
            state_next = ST_WAIT_RDY;
            count_next = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
        ST_WAIT_RDY: begin
          // ready wins over a timeout landing in the same cycle
          if (rdy_sync) begin
            state_next = ST_READY;
            count_next = '0;
          end else if (count == TIMEOUT_LAST) begin
            state_next = ST_FAULT;
            count_next = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
        ST_READY, ST_FAULT: begin
          count_next = count;
        end
        default: begin
          state_next = ST_ASSERT;
          count_next = '0;
        end
      endcase
    end
  end

  assign enter_done  = (state != ST_READY) && (state_next == ST_READY);
  assign enter_fault = (state != ST_FAULT) && (state_next == ST_FAULT);

  // Status outputs are decoded from state_next so the registered outputs
  // line up with the state register on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ASSERT;
      count     <= '0;
      usb_rst_n <= 1'b0;
      busy      <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      seq_count <= 16'd0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      usb_rst_n <= (state_next != ST_ASSERT);
      busy      <= (state_next == ST_ASSERT) || (state_next == ST_SETTLE) ||
                   (state_next == ST_WAIT_RDY);
      ready     <= (state_next == ST_READY);
      fault     <= (state_next == ST_FAULT);
      if (enter_done || enter_fault) begin
        seq_count <= seq_count + 16'd1;
      end
    end
  end

`ifdef USB_RST_IRQ_EN
  logic [1:0] pending, pending_next, pending_clr;

  // Write-1-to-clear; a set in the same cycle as its clear leaves the bit set.
  always_comb begin
    pending_clr = 2'b00;
    if (chipselect && write && (address == 2'd2)) begin
      pending_clr = writedata[1:0];
    end
    pending_next = (pending & ~pending_clr) | {enter_fault, enter_done};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 2'b00;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= |pending_next;
    end
  end

  assign pending_rd = pending;
`else
  assign pending_rd = 2'b00;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'd0;
    unique case (address)
      2'd0:    rd_mux[5:0]  = {3'(state), fault, busy, ready};
      2'd1:    rd_mux[15:0] = seq_count;
      2'd2:    rd_mux[1:0]  = pending_rd;
      default: rd_mux       = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (chipselect && read) begin
      readdata <= rd_mux;
    end
  end

  // Write data is only partly decoded (and not at all without the IRQ feature).
  assign unused_bits = &{1'b0, writedata, write};

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed testbench for usb_rst_sequencer with RST_CYCLES=4,
// SETTLE_CYCLES=8, TIMEOUT_CYCLES=16. Inputs change on the falling edge and
// outputs are sampled on a later falling edge.
module tb_usb_rst_sequencer;

`ifdef USB_RST_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_in;
  logic        ready_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        busy;
  logic        ready;
  logic        fault;
  logic        irq;

  int checkCount = 0;
  int passCount  = 0;

  usb_rst_sequencer #(
    .RST_CYCLES(4),
    .SETTLE_CYCLES(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_in(req_in),
    .ready_in(ready_in),
    .address(address),
    .chipselect(chipselect),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .usb_rst_n(usb_rst_n),
    .busy(busy),
    .ready(ready),
    .fault(fault),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {usb_rst_n, busy, ready, fault} after 'cycles' rising edges
  typedef struct packed {
    logic       req;
    logic       rdy;
    logic [7:0] cycles;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [24];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic rdy, input int cycles);
    req_in   = req;
    ready_in = rdy;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkStatus(input string name, input logic [3:0] want);
    checkOutput(name, {28'd0, usb_rst_n, busy, ready, fault}, {28'd0, want});
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i].req, vecs[i].rdy, int'(vecs[i].cycles));
      checkStatus($sformatf("vec%0d", i), vecs[i].exp);
    end
  endtask

  task automatic readReg(input logic [1:0] a, input logic [31:0] want, input string name);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    checkOutput(name, readdata, want);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] data);
    address    = a;
    writedata  = data;
    chipselect = 1'b1;
    write      = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
  endtask

  // One req_in pulse with ready_in high: READY is reached 13 edges later.
  task automatic runToReady(input string name);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 12);
    checkStatus({name, "_wait"}, 4'b1100);
    applyStimulus(1'b0, 1'b1, 1);
    checkStatus({name, "_ready"}, 4'b1010);
  endtask

  initial begin
    // power-up sequence
    vecs[0]  = '{1'b0, 1'b1, 8'd3,  4'b0100};
    vecs[1]  = '{1'b0, 1'b1, 8'd1,  4'b1100};
    vecs[2]  = '{1'b0, 1'b1, 8'd8,  4'b1100};
    vecs[3]  = '{1'b0, 1'b1, 8'd1,  4'b1010};
    // req_in held high for 20 cycles stretches the pulse
    vecs[4]  = '{1'b1, 1'b1, 8'd1,  4'b0100};
    vecs[5]  = '{1'b1, 1'b1, 8'd19, 4'b0100};
    vecs[6]  = '{1'b0, 1'b1, 8'd1,  4'b1100};
    vecs[7]  = '{1'b0, 1'b1, 8'd7,  4'b1100};
    vecs[8]  = '{1'b0, 1'b1, 8'd1,  4'b1100};
    vecs[9]  = '{1'b0, 1'b1, 8'd1,  4'b1010};
    // ready_in never arrives: FAULT 16 cycles after WAIT_RDY entry
    vecs[10] = '{1'b1, 1'b0, 8'd1,  4'b0100};
    vecs[11] = '{1'b0, 1'b0, 8'd3,  4'b0100};
    vecs[12] = '{1'b0, 1'b0, 8'd1,  4'b1100};
    vecs[13] = '{1'b0, 1'b0, 8'd8,  4'b1100};
    vecs[14] = '{1'b0, 1'b0, 8'd15, 4'b1100};
    vecs[15] = '{1'b0, 1'b0, 8'd1,  4'b1001};
    // new request during SETTLE restarts a full 4-cycle pulse
    vecs[16] = '{1'b1, 1'b1, 8'd1,  4'b0100};
    vecs[17] = '{1'b0, 1'b1, 8'd4,  4'b1100};
    vecs[18] = '{1'b0, 1'b1, 8'd2,  4'b1100};
    vecs[19] = '{1'b1, 1'b1, 8'd1,  4'b0100};
    vecs[20] = '{1'b0, 1'b1, 8'd3,  4'b0100};
    vecs[21] = '{1'b0, 1'b1, 8'd1,  4'b1100};
    vecs[22] = '{1'b0, 1'b1, 8'd8,  4'b1100};
    vecs[23] = '{1'b0, 1'b1, 8'd1,  4'b1010};

    reset      = 1'b1;
    req_in     = 1'b0;
    ready_in   = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);

    checkStatus("reset_outputs", 4'b0100);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    runVectors(0, 3);
    readReg(2'd0, 32'h19, "status_ready");
    readReg(2'd1, 32'd1, "seq_after_powerup");
    readReg(2'd3, 32'd0, "addr3_zero");
    writeReg(2'd1, 32'h1234);
    readReg(2'd1, 32'd1, "addr1_write_ignored");
    writeReg(2'd0, 32'hFFFF_FFFF);
    readReg(2'd0, 32'h19, "addr0_write_ignored");
    checkOutput("irq_after_ready", {31'd0, irq}, {31'd0, IRQ_EN});

    runVectors(4, 9);
    runVectors(10, 15);
    readReg(2'd0, 32'h24, "status_fault");
    readReg(2'd1, 32'd3, "seq_after_fault");
    readReg(2'd2, IRQ_EN ? 32'h3 : 32'h0, "pending_after_fault");
    checkOutput("irq_after_fault", {31'd0, irq}, {31'd0, IRQ_EN});
    writeReg(2'd2, 32'h3);
    readReg(2'd2, 32'd0, "pending_cleared");
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);

    runVectors(16, 23);
    readReg(2'd1, 32'd4, "seq_after_restart");
    writeReg(2'd2, 32'h3);

    // clear of bit0 lands on the same edge that enters READY
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 12);
    address    = 2'd2;
    writedata  = 32'h1;
    chipselect = 1'b1;
    write      = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    checkStatus("setclr_ready", 4'b1010);
    checkOutput("setclr_irq", {31'd0, irq}, {31'd0, IRQ_EN});
    readReg(2'd2, IRQ_EN ? 32'h1 : 32'h0, "setclr_pending");
    readReg(2'd1, 32'd5, "seq_after_setclr");

    // seq_count wrap from 0xFFFF
    force dut.seq_count = 16'hFFFF;
    @(negedge clk);
    release dut.seq_count;
    readReg(2'd1, 32'hFFFF, "seq_forced");
    runToReady("wrap");
    readReg(2'd1, 32'h0, "seq_wrapped");

    // reset in the middle of SETTLE aborts at once and restarts from ASSERT
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 5);
    #2 reset = 1'b1;
    #1;
    checkStatus("midreset_outputs", 4'b0100);
    checkOutput("midreset_readdata", readdata, 32'd0);
    checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 3);
    checkStatus("restart_assert", 4'b0100);
    applyStimulus(1'b0, 1'b1, 1);
    checkStatus("restart_settle", 4'b1100);
    applyStimulus(1'b0, 1'b1, 9);
    checkStatus("restart_ready", 4'b1010);
    readReg(2'd1, 32'd1, "seq_after_midreset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
